// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: registered execute ALU with iterative RV32M multiply/divide behind valid/ready
module alu_mdu_seq #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      ALUop,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ALUresult,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int CW = $clog2(XLEN) + 1;
   state_t            state;
   logic [4:0]        op_r;
   logic [2*XLEN-1:0] acc, acc_nxt, prod;
   logic [XLEN-1:0]   b, spec_val, spec_in_val, base_res, a_mag, b_mag, q, r, fin_res;
   logic [XLEN:0]     msum, dsh, ddiff;
   logic [CW-1:0]     cnt;
   logic              neg, spec, is_m, s1, s2, n1, n2, div0, ovf, spec_in;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign busy      = state == BUSY;
   always_comb begin
      base_res = '0;
      case (ALUop)
         5'd0: base_res = op1 + op2;
         5'd1: base_res = op1 - op2;
         5'd2: base_res = op1 | op2;
         5'd3: base_res = op1 ^ op2;
         5'd4: base_res = op1 & op2;
         5'd5: base_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
         5'd6: base_res = {{(XLEN-1){1'b0}}, op1 < op2};
         5'd7: base_res = op1 << op2[SHAMT_W-1:0];
         5'd8: base_res = op1 >> op2[SHAMT_W-1:0];
         5'd9: base_res = $signed(op1) >>> op2[SHAMT_W-1:0];
         default: base_res = '0;
      endcase
   end
   // operands are reduced to magnitudes up front; the sign is restored when the result is selected
   assign is_m  = ALUop >= 5'd10 && ALUop <= 5'd17;
   assign s1    = ALUop inside {5'd10, 5'd11, 5'd12, 5'd14, 5'd16};
   assign s2    = ALUop inside {5'd10, 5'd11, 5'd14, 5'd16};
   assign n1    = s1 & op1[XLEN-1];
   assign n2    = s2 & op2[XLEN-1];
   assign a_mag = n1 ? -op1 : op1;
   assign b_mag = n2 ? -op2 : op2;
   assign div0  = op2 == '0;
   assign ovf   = op1 == {1'b1, {(XLEN-1){1'b0}}} && op2 == '1 && (ALUop == 5'd14 || ALUop == 5'd16);
   assign spec_in     = ALUop >= 5'd14 && (div0 || ovf);
   assign spec_in_val = ALUop < 5'd16 ? (div0 ? '1 : op1) : (div0 ? op1 : '0);
   // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide
   assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b & {XLEN{acc[0]}}};
   assign dsh     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign ddiff   = dsh - {1'b0, b};
   assign acc_nxt = op_r < 5'd14 ? {msum, acc[XLEN-1:1]} :
                    ddiff[XLEN] ? {dsh[XLEN-1:0], acc[XLEN-2:0], 1'b0} :
                                  {ddiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   assign prod    = neg ? -acc_nxt : acc_nxt;
   assign q       = neg ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
   assign r       = neg ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
   assign fin_res = spec ? spec_val : op_r == 5'd10 ? prod[XLEN-1:0] :
                    op_r < 5'd14 ? prod[2*XLEN-1:XLEN] : op_r < 5'd16 ? q : r;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ALUresult <= '0;
         acc       <= '0;
         b         <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         spec      <= 1'b0;
         spec_val  <= '0;
         op_r      <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_r <= ALUop;
               if (is_m) begin
                  acc      <= {{XLEN{1'b0}}, a_mag};
                  b        <= b_mag;
                  cnt      <= CW'(XLEN);
                  neg      <= ALUop == 5'd16 ? n1 : n1 ^ n2;
                  spec     <= spec_in;
                  spec_val <= spec_in_val;
                  state    <= BUSY;
               end else begin
                  ALUresult <= base_res;
                  state     <= DONE;
               end
            end
            BUSY: begin
               acc <= acc_nxt;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  ALUresult <= fin_res;
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: directed checks of base ops, M ops, handshake, backpressure and reset
module tb_alu_mdu_seq;
   logic        clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [4:0]  ALUop;
   logic [31:0] op1, op2, ALUresult;
   int total, bad;

   alu_mdu_seq #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ALUop(ALUop),
      .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
      .ALUresult(ALUresult), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] bb,
                         output logic [31:0] res, output int lat);
      in_valid = 1; ALUop = op; op1 = a; op2 = bb;
      @(posedge clk); #1;
      in_valid = 0; op1 = $urandom; op2 = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = ALUresult;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      total += 4;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (ALUresult !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", ALUresult); end
      rst = 0;
   endtask

   task automatic test_base;
      logic [4:0]  ops[10];
      logic [31:0] va[10], vb[10], ve[10], res;
      int lat;
      ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
      va  = '{32'h7FFFFFFF, 32'h5, 32'hF0F0, 32'hFF00, 32'hFF00, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h1, 32'h80000000, 32'h80000000};
      vb  = '{32'h1, 32'h7, 32'h0F0F, 32'h0FF0, 32'h0FF0, 32'h1, 32'h1, 32'h21, 32'h4, 32'h24};
      ve  = '{32'h80000000, 32'hFFFFFFFE, 32'hFFFF, 32'hF0F0, 32'h0F00, 32'h1, 32'h0, 32'h2,
              32'h08000000, 32'hF8000000};
      for (int i = 0; i < 10; i++) begin
         run_op(ops[i], va[i], vb[i], res, lat);
         total += 2;
         if (res !== ve[i]) begin bad++; $display("FAIL base_op%0d: got %h want %h", ops[i], res, ve[i]); end
         if (lat !== 1) begin bad++; $display("FAIL base_lat_op%0d: got %0d want 1", ops[i], lat); end
      end
   endtask

   task automatic test_undef;
      logic [31:0] res;
      int lat;
      run_op(5'd0, 32'h11, 32'h22, res, lat);
      run_op(5'd25, $urandom, $urandom, res, lat);
      total += 2;
      if (res !== 32'h0) begin bad++; $display("FAIL undef_result: got %h want 0", res); end
      if (lat !== 1) begin bad++; $display("FAIL undef_lat: got %0d want 1", lat); end
   endtask

   task automatic test_mul;
      logic [4:0]  ops[4];
      logic [31:0] ve[4], res;
      int lat;
      ops = '{5'd10, 5'd11, 5'd13, 5'd12};
      ve  = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
         total += 2;
         if (res !== ve[i]) begin bad++; $display("FAIL mul_op%0d: got %h want %h", ops[i], res, ve[i]); end
         if (lat !== 33) begin bad++; $display("FAIL mul_lat_op%0d: got %0d want 33", ops[i], lat); end
      end
   endtask

   task automatic test_div;
      logic [4:0]  ops[10];
      logic [31:0] va[10], vb[10], ve[10], res;
      int lat;
      ops = '{5'd14, 5'd16, 5'd15, 5'd17, 5'd14, 5'd16, 5'd15, 5'd17, 5'd14, 5'd16};
      va  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'h12345678,
              32'hCAFEF00D, 32'hCAFEF00D, 32'h80000000, 32'h80000000};
      vb  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      ve  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'h12345678,
              32'hFFFFFFFF, 32'hCAFEF00D, 32'h80000000, 32'h0};
      for (int i = 0; i < 10; i++) begin
         run_op(ops[i], va[i], vb[i], res, lat);
         total += 2;
         if (res !== ve[i]) begin bad++; $display("FAIL div_vec%0d_op%0d: got %h want %h", i, ops[i], res, ve[i]); end
         if (lat !== 33) begin bad++; $display("FAIL div_lat_vec%0d: got %0d want 33", i, lat); end
      end
   endtask

   task automatic test_backpressure;
      in_valid = 1; ALUop = 5'd0; op1 = 32'd3; op2 = 32'd4;
      @(posedge clk); #1;
      op1 = 32'd100; op2 = 32'd200;
      for (int k = 0; k < 10; k++) begin
         total += 3;
         if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid_c%0d: got %b want 1", k, out_valid); end
         if (ALUresult !== 32'd7) begin bad++; $display("FAIL bp_result_c%0d: got %h want 7", k, ALUresult); end
         if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_c%0d: got %b want 0", k, in_ready); end
         @(posedge clk); #1;
      end
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      total += 3;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
      if (ALUresult !== 32'd7) begin bad++; $display("FAIL bp_release_result: got %h want 7", ALUresult); end
   endtask

   task automatic test_reset_mid;
      bit seen;
      in_valid = 1; ALUop = 5'd15; op1 = 32'd1000; op2 = 32'd3;
      @(posedge clk); #1;
      in_valid = 0;
      total += 2;
      if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
      repeat (9) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      total += 4;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
      if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
      if (ALUresult !== 32'h0) begin bad++; $display("FAIL mid_rst_result: got %h want 0", ALUresult); end
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_no_result: got %b want 0", seen); end
   endtask

   task automatic test_back_to_back;
      int n;
      n = 1; op1 = 32'd1; op2 = 32'd10; ALUop = 5'd0;
      in_valid = 1; out_ready = 1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'(k & 1)) begin bad++; $display("FAIL b2b_out_valid_c%0d: got %b want %0d", k, out_valid, k & 1); end
         if ((k & 1) == 1) begin
            total++;
            if (ALUresult !== 32'(n * 11)) begin bad++; $display("FAIL b2b_result_c%0d: got %h want %h", k, ALUresult, 32'(n * 11)); end
            n++; op1 = 32'(n); op2 = 32'(n * 10);
         end else begin
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_c%0d: got %b want 1", k, in_ready); end
         end
      end
      in_valid = 0; out_ready = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      clk = 0; rst = 1; in_valid = 0; out_ready = 0; ALUop = 0; op1 = 0; op2 = 0;
      total = 0; bad = 0;
      test_reset;
      test_base;
      test_undef;
      test_mul;
      test_div;
      test_backpressure;
      test_reset_mid;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
